dead_time_gen: RTL and testbench
================================

# dead_time_gen

Parametrised multi-channel complementary dead-time generator for the PWM output stage. Each channel takes one PWM command bit and drives a high-side/low-side gate pair (A/B) so that both are never high together. It inserts a programmable dead interval before each turn-on, set independently for A and B to cover asymmetric switch delays. The block also provides a global enable, a latched fault shutdown, and per-channel status. It sits between the PWM carrier/comparator logic and the gate-driver output pins.

## Interface
- N_CH, default 3: number of complementary channels (legs).
- DT_W, default 8: width of the dead-time values and of the per-channel counters.

- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  global enable; low forces all outputs low.
- pwm  input  N_CH  PWM command per channel; 1 requests A on, 0 requests B on. Synchronous to clk.
- dtime_a  input  DT_W  dead cycles inserted before any A turn-on.
- dtime_b  input  DT_W  dead cycles inserted before any B turn-on.
- fault  input  1  synchronous fault request; forces a shutdown.
- fault_clr  input  1  clears the latched fault.
- pwmout_a  output  N_CH  high-side gate command per channel, registered.
- pwmout_b  output  N_CH  low-side gate command per channel, registered.
- dead_active  output  N_CH  1 while the channel is in a dead state.
- fault_latched  output  1  sticky fault flag.

## Operation
- Each channel runs an independent FSM with five states: IDLE, DEAD_A, A_ON, DEAD_B, B_ON.
- Outputs per state:
  - A_ON: a=1, b=0.
  - B_ON: a=0, b=1.
  - All other states: a=0, b=0.
- dead_active=1 in DEAD_A and DEAD_B only.
- Each channel has a DT_W-bit counter cnt and a latched target dt_cur.
- Transitions from IDLE, taken when en=1 and there is no fault:
  - pwm=1 goes to DEAD_A.
  - pwm=0 goes to DEAD_B.
  - Start-up therefore always inserts dead time.
- From A_ON with pwm=0:
  - If dtime_b=0, go directly to B_ON.
  - Otherwise go to DEAD_B with cnt=1 and dt_cur=dtime_b.
- From B_ON with pwm=1: symmetric to the above, using dtime_a and DEAD_A.
- In DEAD_x, on each edge:
  - If pwm still requests x and cnt==dt_cur, go to x_ON.
  - If pwm still requests x and cnt!=dt_cur, increment cnt.
  - If pwm reverses, switch to the opposite dead state: cnt=1, dt_cur=the opposite dtime. If that dtime is 0, go to the opposite ON state instead.
- Entering DEAD_x from IDLE: if the relevant dtime=0, go directly to x_ON on that edge.
- dt_cur is captured on dead-state entry. Changing dtime_a/dtime_b mid-dead does not affect the interval in progress.
- cnt never exceeds dt_cur, so there is no wrap-around. The maximum interval is 2^DT_W-1 cycles.
- en=0 sends all channels to IDLE on the next edge, with outputs low.
- Fault handling:
  - fault=1 at an edge sets fault_latched and sends all channels to IDLE, regardless of en.
  - The channels stay in IDLE while fault_latched=1.
  - fault_clr=1 with fault=0 clears fault_latched.
  - If fault and fault_clr are both high, fault wins.
- Invariant: pwmout_a[i] & pwmout_b[i] is never 1.

## Timing
- Reset (asynchronous): all pwmout_a, pwmout_b and dead_active are 0, fault_latched=0, states are IDLE, cnt=0 and dt_cur=0. Outputs stay low until the first edge after reset deasserts.
- pwm is sampled directly at edge k. Output changes are visible after edge k (one-cycle latency).
- A to B transition:
  - pwm falls before edge k.
  - pwmout_a goes low after edge k.
  - Both outputs are low for exactly dtime_b cycles.
  - pwmout_b goes high after edge k+dtime_b.
- B to A transition is symmetric, using dtime_a.
- Shutdown latency: en or fault seen at edge k gives outputs low after edge k.
- Recovery after fault_clr at edge k:
  - The channel is IDLE after edge k.
  - It enters a dead state at edge k+1.
  - The first turn-on happens at edge k+1+dt.

## Test plan
- Basic inserts dead time: N_CH=3, dtime_a=4, dtime_b=6, pwm[0] toggling with a period of 40 -> pwmout_b[0] rises 6 cycles after pwmout_a[0] falls, and pwmout_a[0] rises 4 cycles after pwmout_b[0] falls; a&b is never high.
- Zero dead time: dtime_a=dtime_b=0 -> pwmout_a equals pwm delayed by 1 cycle, pwmout_b is its complement, and dead_active stays 0 after start-up.
- Short pulse during dead time: dtime_a=10, pwm high for 3 cycles then low -> pwmout_a never rises, the channel goes to DEAD_B, and pwmout_b rises dtime_b cycles after the reversal.
- Mid-dead change: change dtime_b from 6 to 2 during a DEAD_B interval -> the current interval stays 6 cycles and the next interval is 2.
- Fault: assert fault for 1 cycle while channels are in A_ON -> all outputs low the next cycle and fault_latched=1; fault_clr with fault=0 -> outputs resume after dt cycles; fault and fault_clr together -> latch stays set.
- Async reset mid-operation, plus en=0 -> outputs go low immediately on reset, or one cycle after en falls; on release, every channel re-enters through a dead state.

Source files
------------

// File: rtl/dead_time_gen.sv
// dead_time_gen
//   Multi-channel complementary dead-time generator. Each channel turns one
//   PWM command bit into a high-side/low-side gate pair (A/B). Both gates are
//   never high together. A programmable dead interval (dtime_a / dtime_b) is
//   inserted before every turn-on. A global enable and a latched fault both
//   force every channel back to IDLE with its gates off.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   en             : global enable; low parks every channel in IDLE
//   pwm[N_CH]      : per-channel command, 1 = A on, 0 = B on
//   dtime_a/_b     : dead cycles inserted before an A / B turn-on
//   fault          : synchronous shutdown request; sets the sticky flag
//   fault_clr      : clears the sticky flag (fault wins if both are high)
//   pwmout_a/_b    : registered gate commands per channel
//   dead_active    : channel is in DEAD_A or DEAD_B
//   fault_latched  : sticky fault flag

// One complementary leg: the FSM, its dead counter and the registered outputs.
module dead_time_ch #(
   parameter int DT_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            force_idle,
   input  logic            pwm,
   input  logic [DT_W-1:0] dtime_a,
   input  logic [DT_W-1:0] dtime_b,
   output logic            out_a,
   output logic            out_b,
   output logic            dead
);

   typedef enum logic [2:0] {IDLE, DEAD_A, A_ON, DEAD_B, B_ON} state_t;

   state_t          state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic [DT_W-1:0] dt_cur_q, dt_cur_d;
   logic            out_a_q, out_a_d;
   logic            out_b_q, out_b_d;
   logic            dead_q, dead_d;
   logic            enter_a, enter_b;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dt_cur_d = dt_cur_q;
      enter_a  = 1'b0;
      enter_b  = 1'b0;

      if (force_idle) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE:    if (pwm) enter_a = 1'b1; else enter_b = 1'b1;
            A_ON:    if (!pwm) enter_b = 1'b1;
            B_ON:    if (pwm) enter_a = 1'b1;
            DEAD_A: begin
               if (!pwm)                    enter_b = 1'b1;
               else if (cnt_q == dt_cur_q)  state_d = A_ON;
               else                         cnt_d   = cnt_q + DT_W'(1);
            end
            DEAD_B: begin
               if (pwm)                     enter_a = 1'b1;
               else if (cnt_q == dt_cur_q)  state_d = B_ON;
               else                         cnt_d   = cnt_q + DT_W'(1);
            end
            default: state_d = IDLE;
         endcase

         // Every turn-on request funnels through here. The dead interval
         // starts with cnt=1 on this edge, so the switch turns on after
         // exactly dt dead cycles. dt_cur freezes the target, so later
         // dtime changes do not stretch or cut the interval in progress.
         if (enter_a) begin
            if (dtime_a == '0) begin
               state_d = A_ON;
            end else begin
               state_d  = DEAD_A;
               cnt_d    = DT_W'(1);
               dt_cur_d = dtime_a;
            end
         end else if (enter_b) begin
            if (dtime_b == '0) begin
               state_d = B_ON;
            end else begin
               state_d  = DEAD_B;
               cnt_d    = DT_W'(1);
               dt_cur_d = dtime_b;
            end
         end
      end

      // Outputs are decoded from the next state and then registered. They
      // therefore track the state register without a combinational path
      // to the pins.
      out_a_d = (state_d == A_ON);
      out_b_d = (state_d == B_ON);
      dead_d  = (state_d == DEAD_A) || (state_d == DEAD_B);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         dt_cur_q <= '0;
         out_a_q  <= 1'b0;
         out_b_q  <= 1'b0;
         dead_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dt_cur_q <= dt_cur_d;
         out_a_q  <= out_a_d;
         out_b_q  <= out_b_d;
         dead_q   <= dead_d;
      end
   end

   assign out_a = out_a_q;
   assign out_b = out_b_q;
   assign dead  = dead_q;

endmodule

module dead_time_gen #(
   parameter int N_CH = 3,
   parameter int DT_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [N_CH-1:0] pwm,
   input  logic [DT_W-1:0] dtime_a,
   input  logic [DT_W-1:0] dtime_b,
   input  logic            fault,
   input  logic            fault_clr,
   output logic [N_CH-1:0] pwmout_a,
   output logic [N_CH-1:0] pwmout_b,
   output logic [N_CH-1:0] dead_active,
   output logic            fault_latched
);

   logic fault_latched_q, fault_latched_d;
   logic force_idle;

   // A new fault takes priority over a simultaneous clear.
   always_comb begin
      fault_latched_d = fault | (fault_latched_q & ~fault_clr);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fault_latched_q <= 1'b0;
      else       fault_latched_q <= fault_latched_d;
   end

   // The registered flag (not its next value) gates the channels. On the
   // clearing edge the legs are therefore still held in IDLE, and they
   // restart one edge later.
   assign force_idle    = ~en | fault | fault_latched_q;
   assign fault_latched = fault_latched_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      dead_time_ch #(.DT_W(DT_W)) u_ch (
         .clk        (clk),
         .reset      (reset),
         .force_idle (force_idle),
         .pwm        (pwm[i]),
         .dtime_a    (dtime_a),
         .dtime_b    (dtime_b),
         .out_a      (pwmout_a[i]),
         .out_b      (pwmout_b[i]),
         .dead       (dead_active[i])
      );
   end

endmodule

// File: tb/tb_dead_time_gen.sv
// Testbench for dead_time_gen. The driver applies inputs 2 time units after
// each rising edge. It then advances a behavioural model (side / on /
// remaining-dead-cycles per channel) for the coming edge and pushes the
// expected outputs into a queue. The monitor pops one entry 1 time unit after
// each edge and compares it with the outputs.
module tb_dead_time_gen;
   localparam int N_CH = 3;
   localparam int DT_W = 8;

   logic            clk = 1'b0;
   logic            reset, en, fault, fault_clr;
   logic [N_CH-1:0] pwm;
   logic [DT_W-1:0] dtime_a, dtime_b;
   logic [N_CH-1:0] pwmout_a, pwmout_b, dead_active;
   logic            fault_latched;

   always #5 clk = ~clk;

   dead_time_gen #(.N_CH(N_CH), .DT_W(DT_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .pwm           (pwm),
      .dtime_a       (dtime_a),
      .dtime_b       (dtime_b),
      .fault         (fault),
      .fault_clr     (fault_clr),
      .pwmout_a      (pwmout_a),
      .pwmout_b      (pwmout_b),
      .dead_active   (dead_active),
      .fault_latched (fault_latched)
   );

   typedef struct packed {
      logic [N_CH-1:0] a;
      logic [N_CH-1:0] b;
      logic [N_CH-1:0] d;
      logic            fl;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Model: side 0 = idle, 1 = heading to / driving A, 2 = B.
   // m_left counts the dead cycles still to go after the current one.
   int m_side[N_CH];
   bit m_on[N_CH];
   int m_left[N_CH];
   bit m_fl;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      exp_t e;
      bit   force_idle;
      int   want, dt;
      if (reset) begin
         m_fl = 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            m_side[i] = 0; m_on[i] = 1'b0; m_left[i] = 0;
         end
      end else begin
         force_idle = !en || fault || m_fl;
         if (fault) m_fl = 1'b1;
         else if (fault_clr) m_fl = 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            if (force_idle) begin
               m_side[i] = 0; m_on[i] = 1'b0;
            end else begin
               want = pwm[i] ? 1 : 2;
               dt   = (want == 1) ? int'(dtime_a) : int'(dtime_b);
               if (m_side[i] != want) begin
                  m_side[i] = want;
                  m_on[i]   = (dt == 0);
                  m_left[i] = dt - 1;
               end else if (!m_on[i]) begin
                  if (m_left[i] == 0) m_on[i] = 1'b1;
                  else                m_left[i]--;
               end
            end
         end
      end
      for (int i = 0; i < N_CH; i++) begin
         e.a[i] = (m_side[i] == 1) && m_on[i];
         e.b[i] = (m_side[i] == 2) && m_on[i];
         e.d[i] = (m_side[i] != 0) && !m_on[i];
      end
      e.fl = m_fl;
      sb_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic check_outputs_low(input string tag);
      check({tag, "_a"},  32'(pwmout_a), 32'd0);
      check({tag, "_b"},  32'(pwmout_b), 32'd0);
      check({tag, "_dead"}, 32'(dead_active), 32'd0);
      check({tag, "_fl"}, 32'(fault_latched), 32'd0);
   endtask

   // Monitor
   exp_t mon_e;
   always begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         mon_e = sb_q.pop_front();
         check("pwmout_a",      32'(pwmout_a),      32'(mon_e.a));
         check("pwmout_b",      32'(pwmout_b),      32'(mon_e.b));
         check("dead_active",   32'(dead_active),   32'(mon_e.d));
         check("fault_latched", 32'(fault_latched), 32'(mon_e.fl));
      end
      check("a_b_overlap", 32'(pwmout_a & pwmout_b), 32'd0);
   end

   initial begin
      reset = 1'b0; en = 1'b0; fault = 1'b0; fault_clr = 1'b0;
      pwm = '0; dtime_a = 8'd4; dtime_b = 8'd6;
      #1 reset = 1'b1;
      #1;
      check_outputs_low("reset");
      run(2);
      reset = 1'b0;
      en    = 1'b1;

      // Basic dead-time insertion on several legs with different periods
      for (int c = 0; c < 120; c++) begin
         pwm[0] = (c % 40) < 20;
         pwm[1] = 1'b1;
         pwm[2] = (c % 30) < 15;
         step();
      end

      // Zero dead time: outputs follow pwm with one cycle latency
      dtime_a = 8'd0; dtime_b = 8'd0;
      for (int c = 0; c < 60; c++) begin
         pwm = N_CH'($urandom);
         step();
      end

      // Short pulse shorter than dtime_a
      dtime_a = 8'd10; dtime_b = 8'd6;
      pwm = '0;   run(20);
      pwm[0] = 1'b1; run(3);
      pwm[0] = 1'b0; run(20);

      // dtime_b changed in the middle of a DEAD_B interval
      dtime_a = 8'd4;
      pwm = '1; run(20);
      pwm = '0; run(2);
      dtime_b = 8'd2; run(15);
      pwm = '1; run(15);
      pwm = '0; run(10);

      // Largest dead interval
      dtime_b = 8'd255;
      pwm = '1; run(10);
      pwm = '0; run(262);
      dtime_b = 8'd6;

      // Fault, fault+clear together, then clear
      pwm = '1; run(20);
      fault = 1'b1; run(1);
      fault = 1'b0; run(5);
      fault = 1'b1; fault_clr = 1'b1; run(1);
      fault = 1'b0; fault_clr = 1'b0; run(3);
      fault_clr = 1'b1; run(1);
      fault_clr = 1'b0; run(15);

      // Enable drop
      en = 1'b0; run(5);
      en = 1'b1; pwm = 3'b010; run(12);

      // Async reset mid-operation with fault latched
      fault = 1'b1; run(1);
      fault = 1'b0; run(2);
      reset = 1'b1;
      #1;
      check_outputs_low("reset_mid");
      run(2);
      reset = 1'b0; run(20);

      // Randomised run
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N_CH; i++)
            if ($urandom_range(0, 9) == 0) pwm[i] = ~pwm[i];
         if ($urandom_range(0, 49) == 0) dtime_a = DT_W'($urandom_range(0, 12));
         if ($urandom_range(0, 49) == 0) dtime_b = DT_W'($urandom_range(0, 12));
         en        = ($urandom_range(0, 99) != 0);
         fault     = ($urandom_range(0, 199) == 0);
         fault_clr = ($urandom_range(0, 19) == 0);
         step();
      end
      fault = 1'b0; fault_clr = 1'b0;

      for (int i = 0; i < 5 && sb_q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      check("scoreboard_drain", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
